// File: rtl/eth_user_pkg.sv
// Shared types and constants for the user-side Ethernet transmit path.
package eth_user_pkg;

  localparam int AXIS_DATA_W     = 32;
  localparam int AXIS_STRB_W     = AXIS_DATA_W / 8;
  localparam int MAX_FRAME_BYTES = 1518;

  typedef struct packed {
    logic                   last;
    logic [AXIS_STRB_W-1:0] strb;
    logic [AXIS_DATA_W-1:0] data;
  } axis_word_t;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  function automatic int bytesToWords(input int nBytes);
    return (nBytes + AXIS_STRB_W - 1) / AXIS_STRB_W;
  endfunction

endpackage

// File: rtl/axis_user_tx_fifo_if.sv
// AXI-Stream handshake bundle used on both sides of the user transmit FIFO.
interface axis_user_tx_fifo_if;
  import eth_user_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_STRB_W-1:0] tstrb;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tstrb, input tlast, input tvalid, output tready);

endinterface

// File: rtl/user_fifo_ram.sv
// Single-clock register-array storage for the transmit FIFO; reads are combinational.
module user_fifo_ram
  import eth_user_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk_user,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  axis_word_t        i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output axis_word_t        o_rdData
);

  axis_word_t r_mem [DEPTH];

  always_ff @(posedge Clk_user) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/axis_user_tx_fifo.sv
// Store-and-forward packet FIFO between the user source and the MAC transmit path.
// Define USER_TX_OVERSIZE_DROP_EN to discard packets longer than MAX_PKT_WORDS.
module axis_user_tx_fifo
  import eth_user_pkg::*;
#(
  parameter int DEPTH         = 512,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int MAX_PKT_WORDS = bytesToWords(MAX_FRAME_BYTES)
) (
  input  logic                Reset,
  input  logic                Clk_user,
  input  logic                Tx_en,
  axis_user_tx_fifo_if.slave  S_AXIS,
  axis_user_tx_fifo_if.master M_AXIS,
  output logic [ADDR_W:0]     Pkt_cnt,
  output logic                Fifo_full,
  output logic [15:0]         Drop_cnt
);

  localparam int               PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0] FULL_FILL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || MAX_PKT_WORDS > DEPTH) begin : g_paramCheck
    $error("axis_user_tx_fifo: DEPTH must be a power of 2 >= 4 and MAX_PKT_WORDS <= DEPTH");
  end

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_wrCommit;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_pktCnt;
  logic [PTR_W-1:0] w_fill;
  logic             w_full;
  logic             w_sReady;
  logic             w_accept;
  logic             w_wrEn;
  logic             w_commit;
  logic             w_rewind;
  logic             w_readable;
  logic             w_load;
  logic             w_mHandshake;
  logic             w_lastHandshake;
  axis_word_t       w_inWord;
  axis_word_t       w_rdWord;
  axis_word_t       r_outWord;
  logic             r_outValid;
  tx_state_t        r_state;
  tx_state_t        w_nextState;

  assign w_fill   = r_wrPtr - r_rdPtr;
  assign w_full   = (w_fill == FULL_FILL);
  assign w_inWord = {S_AXIS.tlast, S_AXIS.tstrb, S_AXIS.tdata};

`ifdef USER_TX_OVERSIZE_DROP_EN
  logic             r_dropping;
  logic [PTR_W-1:0] r_wordCnt;
  logic [15:0]      r_dropCnt;
  logic             w_atMax;

  // Word MAX_PKT_WORDS+1 is always taken (even when storage is full) so an
  // oversize packet can never wedge the input behind uncommitted words.
  assign w_atMax  = (r_wordCnt == PTR_W'(MAX_PKT_WORDS));
  assign w_sReady = ~Reset & (~w_full | r_dropping | w_atMax);
  assign w_accept = S_AXIS.tvalid & w_sReady;
  assign w_rewind = w_accept & ~r_dropping & w_atMax;
  assign w_wrEn   = w_accept & ~r_dropping & ~w_atMax;
  assign Drop_cnt = r_dropCnt;

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      r_dropping <= 1'b0;
      r_wordCnt  <= '0;
      r_dropCnt  <= '0;
    end else if (w_accept) begin
      if (r_dropping | w_atMax) begin
        if (S_AXIS.tlast) begin
          r_dropping <= 1'b0;
          r_wordCnt  <= '0;
          if (r_dropCnt != 16'hFFFF) r_dropCnt <= r_dropCnt + 16'd1;
        end else begin
          r_dropping <= 1'b1;
        end
      end else if (S_AXIS.tlast) begin
        r_wordCnt <= '0;
      end else begin
        r_wordCnt <= r_wordCnt + PTR_ONE;
      end
    end
  end
`else
  assign w_sReady = ~Reset & ~w_full;
  assign w_accept = S_AXIS.tvalid & w_sReady;
  assign w_rewind = 1'b0;
  assign w_wrEn   = w_accept;
  assign Drop_cnt = 16'd0;
`endif

  assign S_AXIS.tready = w_sReady;
  assign w_commit      = w_wrEn & S_AXIS.tlast;

  user_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clk_user (Clk_user),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
    .i_wrData (w_inWord),
    .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
    .o_rdData (w_rdWord)
  );

  // wr_ptr runs ahead speculatively; only wr_commit exposes words to the reader.
  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      r_wrPtr    <= '0;
      r_wrCommit <= '0;
    end else if (w_rewind) begin
      r_wrPtr <= r_wrCommit;
    end else if (w_wrEn) begin
      r_wrPtr <= r_wrPtr + PTR_ONE;
      if (S_AXIS.tlast) r_wrCommit <= r_wrPtr + PTR_ONE;
    end
  end

  assign w_readable      = (r_rdPtr != r_wrCommit);
  assign w_mHandshake    = r_outValid & M_AXIS.tready;
  assign w_lastHandshake = w_mHandshake & r_outWord.last;

  // IDLE waits for a fully empty output register, which yields the inter-packet bubble.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_readable && Tx_en && !r_outValid) begin
          w_load      = 1'b1;
          w_nextState = w_rdWord.last ? IDLE : SEND;
        end
      end
      SEND: begin
        if (w_readable && (!r_outValid || M_AXIS.tready)) begin
          w_load = 1'b1;
          if (w_rdWord.last) w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_rdPtr    <= '0;
      r_outWord  <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_outWord  <= w_rdWord;
        r_outValid <= 1'b1;
        r_rdPtr    <= r_rdPtr + PTR_ONE;
      end else if (w_mHandshake) begin
        r_outValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      r_pktCnt <= '0;
    end else begin
      case ({w_commit, w_lastHandshake})
        2'b10:   r_pktCnt <= r_pktCnt + PTR_ONE;
        2'b01:   r_pktCnt <= r_pktCnt - PTR_ONE;
        default: r_pktCnt <= r_pktCnt;
      endcase
    end
  end

  assign M_AXIS.tdata  = r_outWord.data;
  assign M_AXIS.tstrb  = r_outWord.strb;
  assign M_AXIS.tlast  = r_outWord.last;
  assign M_AXIS.tvalid = r_outValid;
  assign Pkt_cnt       = r_pktCnt;
  assign Fifo_full     = w_full;

endmodule

// File: tb/tb_axis_user_tx_fifo.sv
// Self-checking bench for axis_user_tx_fifo: directed steps plus a scoreboard queue
// filled as input words are accepted and drained as the MAC side handshakes.
module tb_axis_user_tx_fifo;
  import eth_user_pkg::*;

  localparam int DEPTH         = 16;
  localparam int ADDR_W        = $clog2(DEPTH);
  localparam int MAX_PKT_WORDS = 12;
  localparam int WAIT_LIMIT    = 2000;

  logic            Clk_user = 1'b0;
  logic            Reset    = 1'b1;
  logic            Tx_en    = 1'b0;
  logic [ADDR_W:0] Pkt_cnt;
  logic            Fifo_full;
  logic [15:0]     Drop_cnt;

  axis_user_tx_fifo_if sAxis ();
  axis_user_tx_fifo_if mAxis ();

  int         nAsserts    = 0;
  int         nFails      = 0;
  bit         randomReady = 1'b0;
  axis_word_t expQ[$];

  axis_user_tx_fifo #(
    .DEPTH         (DEPTH),
    .ADDR_W        (ADDR_W),
    .MAX_PKT_WORDS (MAX_PKT_WORDS)
  ) dut (
    .Reset     (Reset),
    .Clk_user  (Clk_user),
    .Tx_en     (Tx_en),
    .S_AXIS    (sAxis),
    .M_AXIS    (mAxis),
    .Pkt_cnt   (Pkt_cnt),
    .Fifo_full (Fifo_full),
    .Drop_cnt  (Drop_cnt)
  );

  always #5 Clk_user = ~Clk_user;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reportTimeout(input string tag);
    nAsserts++;
    nFails++;
    $error("[TB] FAIL %s: observed no progress after %0d cycles expected completion", tag, WAIT_LIMIT);
  endtask

  // Sends the first nSend words of an nWords packet; called and returns at posedge+1.
  task automatic applyStimulus(input int nWords, input int nSend, input logic [3:0] lastStrb,
                               input bit expectOut);
    axis_word_t w;
    int         waitCnt;
    for (int i = 0; i < nSend; i++) begin
      w.last        = (i == nWords - 1);
      w.strb        = w.last ? lastStrb : 4'hF;
      w.data        = $urandom;
      sAxis.tdata   = w.data;
      sAxis.tstrb   = w.strb;
      sAxis.tlast   = w.last;
      sAxis.tvalid  = 1'b1;
      waitCnt       = 0;
      forever begin
        @(negedge Clk_user);
        if (sAxis.tready) break;
        waitCnt++;
        if (waitCnt >= WAIT_LIMIT) break;
      end
      if (waitCnt >= WAIT_LIMIT) begin
        reportTimeout("inputAccept");
        sAxis.tvalid = 1'b0;
        return;
      end
      if (expectOut) expQ.push_back(w);
      @(posedge Clk_user);
      #1;
    end
    sAxis.tvalid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((expQ.size() != 0 || mAxis.tvalid) && n < WAIT_LIMIT) begin
      @(posedge Clk_user);
      #1;
      n++;
    end
    if (n >= WAIT_LIMIT) reportTimeout(tag);
  endtask

  // Output monitor: scoreboard compare, stall stability and the post-packet bubble.
  logic       prevStall  = 1'b0;
  logic       prevLastHs = 1'b0;
  axis_word_t prevWord;
  axis_word_t obsWord;
  axis_word_t expWord;

  always @(negedge Clk_user) begin
    if (Reset) begin
      prevStall  = 1'b0;
      prevLastHs = 1'b0;
    end else begin
      obsWord = {mAxis.tlast, mAxis.tstrb, mAxis.tdata};
      if (prevStall) begin
        checkOutput("stallTvalid", mAxis.tvalid, 1'b1);
        checkOutput("stallWord", obsWord, prevWord);
      end
      if (prevLastHs) checkOutput("bubble", mAxis.tvalid, 1'b0);
      if (mAxis.tvalid && mAxis.tready) begin
        if (expQ.size() == 0) begin
          nAsserts++;
          nFails++;
          $error("[TB] FAIL unexpectedWord: observed 0x%0h expected no output", obsWord);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("outWord", obsWord, expWord);
        end
      end
      prevStall  = mAxis.tvalid & ~mAxis.tready;
      prevWord   = obsWord;
      prevLastHs = mAxis.tvalid & mAxis.tready & mAxis.tlast;
    end
  end

  always @(posedge Clk_user) begin
    if (randomReady) begin
      #1;
      mAxis.tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed simulation still running expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    sAxis.tdata  = '0;
    sAxis.tstrb  = '0;
    sAxis.tlast  = 1'b0;
    sAxis.tvalid = 1'b0;
    mAxis.tready = 1'b0;

    repeat (3) @(posedge Clk_user);
    #1;
    checkOutput("rstTvalid", mAxis.tvalid, 1'b0);
    checkOutput("rstSReady", sAxis.tready, 1'b0);
    checkOutput("rstPktCnt", Pkt_cnt, 0);
    checkOutput("rstFull", Fifo_full, 1'b0);
    checkOutput("rstDropCnt", Drop_cnt, 0);
    Reset = 1'b0;
    #1;
    checkOutput("relSReady", sAxis.tready, 1'b1);
    @(posedge Clk_user);
    #1;

    $display("[TB] single 4-word packet latency");
    Tx_en        = 1'b1;
    mAxis.tready = 1'b1;
    applyStimulus(4, 4, 4'b0011, 1'b1);
    checkOutput("latE0Tvalid", mAxis.tvalid, 1'b0);
    checkOutput("pktCntCommit", Pkt_cnt, 1);
    @(posedge Clk_user);
    #1;
    checkOutput("latE1Tvalid", mAxis.tvalid, 1'b1);
    checkOutput("pktCntLoaded", Pkt_cnt, 1);
    waitDrain("drainSingle");
    checkOutput("pktCntDrained", Pkt_cnt, 0);

    $display("[TB] Tx_en hold and release");
    Tx_en = 1'b0;
    applyStimulus(4, 4, 4'hF, 1'b1);
    applyStimulus(5, 5, 4'b0001, 1'b1);
    applyStimulus(3, 3, 4'b0111, 1'b1);
    repeat (5) @(posedge Clk_user);
    #1;
    checkOutput("holdTvalid", mAxis.tvalid, 1'b0);
    checkOutput("holdPktCnt", Pkt_cnt, 3);
    Tx_en = 1'b1;
    waitDrain("drainThree");
    checkOutput("threePktCnt", Pkt_cnt, 0);

    Tx_en = 1'b0;
    applyStimulus(4, 4, 4'b0011, 1'b1);
    applyStimulus(4, 4, 4'hF, 1'b1);
    Tx_en = 1'b1;
    repeat (2) @(posedge Clk_user);
    #1;
    Tx_en = 1'b0;
    repeat (20) @(posedge Clk_user);
    #1;
    checkOutput("txEnRemain", expQ.size(), 4);
    checkOutput("txEnTvalid", mAxis.tvalid, 1'b0);
    checkOutput("txEnPktCnt", Pkt_cnt, 1);
    Tx_en = 1'b1;
    waitDrain("drainTxEn");

    $display("[TB] storage full");
    Tx_en        = 1'b0;
    mAxis.tready = 1'b0;
    applyStimulus(8, 8, 4'hF, 1'b1);
    applyStimulus(8, 8, 4'b0011, 1'b1);
    checkOutput("fullFlag", Fifo_full, 1'b1);
    checkOutput("fullSReady", sAxis.tready, 1'b0);
    checkOutput("fullPktCnt", Pkt_cnt, 2);
    Tx_en = 1'b1;
    @(posedge Clk_user);
    #1;
    checkOutput("spaceSReady", sAxis.tready, 1'b1);
    checkOutput("spaceFull", Fifo_full, 1'b0);
    checkOutput("spaceTvalid", mAxis.tvalid, 1'b1);
    repeat (3) @(posedge Clk_user);
    #1;
    mAxis.tready = 1'b1;
    waitDrain("drainFull");

    $display("[TB] random backpressure");
    randomReady = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = int'($urandom_range(1, MAX_PKT_WORDS));
      applyStimulus(len, len, 4'($urandom_range(1, 15)), 1'b1);
    end
    waitDrain("drainRandom");
    randomReady = 1'b0;
    @(posedge Clk_user);
    #1;
    mAxis.tready = 1'b1;
    checkOutput("randomPktCnt", Pkt_cnt, 0);

    $display("[TB] reset mid-packet");
    mAxis.tready = 1'b0;
    applyStimulus(5, 5, 4'hF, 1'b1);
    applyStimulus(6, 2, 4'hF, 1'b0);
    checkOutput("preRstTvalid", mAxis.tvalid, 1'b1);
    Reset = 1'b1;
    #1;
    checkOutput("midRstTvalid", mAxis.tvalid, 1'b0);
    checkOutput("midRstSReady", sAxis.tready, 1'b0);
    checkOutput("midRstPktCnt", Pkt_cnt, 0);
    checkOutput("midRstFull", Fifo_full, 1'b0);
    checkOutput("midRstDropCnt", Drop_cnt, 0);
    expQ.delete();
    @(posedge Clk_user);
    #1;
    Reset = 1'b0;
    @(posedge Clk_user);
    #1;
    mAxis.tready = 1'b1;
    applyStimulus(3, 3, 4'b0111, 1'b1);
    waitDrain("drainPostRst");
    repeat (10) @(posedge Clk_user);
    #1;
    checkOutput("postRstTvalid", mAxis.tvalid, 1'b0);
    checkOutput("postRstPktCnt", Pkt_cnt, 0);

`ifdef USER_TX_OVERSIZE_DROP_EN
    $display("[TB] oversize drop");
    applyStimulus(MAX_PKT_WORDS + 1, MAX_PKT_WORDS + 1, 4'hF, 1'b0);
    applyStimulus(4, 4, 4'b0011, 1'b1);
    waitDrain("drainDrop1");
    checkOutput("dropCnt1", Drop_cnt, 1);
    applyStimulus(MAX_PKT_WORDS + 5, MAX_PKT_WORDS + 5, 4'b0001, 1'b0);
    applyStimulus(MAX_PKT_WORDS, MAX_PKT_WORDS, 4'b0111, 1'b1);
    waitDrain("drainDrop2");
    checkOutput("dropCnt2", Drop_cnt, 2);
    checkOutput("dropPktCnt", Pkt_cnt, 0);
`else
    $display("[TB] long packet stored without drop logic");
    applyStimulus(MAX_PKT_WORDS + 1, MAX_PKT_WORDS + 1, 4'hF, 1'b1);
    applyStimulus(4, 4, 4'b0011, 1'b1);
    waitDrain("drainLong");
    checkOutput("noDropCnt", Drop_cnt, 0);
    checkOutput("longPktCnt", Pkt_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
